// File: rtl/qsys_data_mem_arbiter.sv
// rtl/qsys_data_mem_arbiter.sv - two-master Avalon-MM arbiter for one shared single-port data memory
//
// Purpose: shares one byte-enabled single-port on-chip RAM (registered address,
// unregistered q) between two Avalon-MM masters. One transfer is accepted per
// cycle, chosen round-robin or with m0 at fixed priority. Read data comes back
// exactly one cycle after acceptance, qualified by a per-master readdatavalid.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   freeze            1 = accept nothing new and hold the memory clock enable low
//   m0_* / m1_*       Avalon-MM slave side for each master: address, byteenable,
//                     read, write, writedata, waitrequest, readdata, readdatavalid
//   mem_*             memory s1 side: address, byteenable, chipselect, write,
//                     writedata, clken (outputs) and readdata (input, the RAM q)
module qsys_data_mem_arbiter #(
  parameter int AW          = 12,
  parameter int DW          = 32,
  parameter int ROUND_ROBIN = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            freeze,
  input  logic [AW-1:0]   m0_address,
  input  logic [DW/8-1:0] m0_byteenable,
  input  logic            m0_read,
  input  logic            m0_write,
  input  logic [DW-1:0]   m0_writedata,
  output logic            m0_waitrequest,
  output logic [DW-1:0]   m0_readdata,
  output logic            m0_readdatavalid,
  input  logic [AW-1:0]   m1_address,
  input  logic [DW/8-1:0] m1_byteenable,
  input  logic            m1_read,
  input  logic            m1_write,
  input  logic [DW-1:0]   m1_writedata,
  output logic            m1_waitrequest,
  output logic [DW-1:0]   m1_readdata,
  output logic            m1_readdatavalid,
  output logic [AW-1:0]   mem_address,
  output logic [DW/8-1:0] mem_byteenable,
  output logic            mem_chipselect,
  output logic            mem_write,
  output logic [DW-1:0]   mem_writedata,
  output logic            mem_clken,
  input  logic [DW-1:0]   mem_readdata
);

  localparam int   BW = DW / 8;
  localparam logic RR = (ROUND_ROBIN != 0);

  // prio names the master that wins a simultaneous request (0 = m0, 1 = m1).
  logic          prio;
  logic          rd_pend;
  logic          rd_owner;
  logic [AW-1:0] last_address;
  logic [DW-1:0] last_writedata;

  logic          req0;
  logic          req1;
  logic          active;
  logic          gnt0;
  logic          gnt1;
  logic          gnt_any;
  logic [AW-1:0] sel_address;
  logic [DW-1:0] sel_writedata;
  logic [BW-1:0] sel_byteenable;
  logic          sel_write;

  assign req0    = m0_read | m0_write;
  assign req1    = m1_read | m1_write;
  assign active  = ~reset & ~freeze;
  assign gnt_any = gnt0 | gnt1;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (active) begin
      if (req0 && req1) begin
        if (RR && prio) gnt1 = 1'b1;
        else            gnt0 = 1'b1;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // A master asserting read and write together is treated as a write.
  // With no grant the address/data buses keep the last granted values so the
  // RAM's address register sees no spurious toggling.
  always_comb begin
    sel_address    = last_address;
    sel_writedata  = last_writedata;
    sel_byteenable = {BW{1'b1}};
    sel_write      = 1'b0;
    if (gnt0) begin
      sel_address    = m0_address;
      sel_writedata  = m0_writedata;
      sel_write      = m0_write;
      sel_byteenable = m0_write ? m0_byteenable : {BW{1'b1}};
    end else if (gnt1) begin
      sel_address    = m1_address;
      sel_writedata  = m1_writedata;
      sel_write      = m1_write;
      sel_byteenable = m1_write ? m1_byteenable : {BW{1'b1}};
    end
  end

  assign m0_waitrequest = ~gnt0;
  assign m1_waitrequest = ~gnt1;

  assign mem_address    = sel_address;
  assign mem_writedata  = sel_writedata;
  assign mem_byteenable = sel_byteenable;
  assign mem_chipselect = gnt_any;
  assign mem_write      = sel_write;
  assign mem_clken      = ~freeze;

  // RAM q is shared; only the valid strobe is steered to the read's owner.
  // The reset term blanks a pending strobe during the reset cycle itself.
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = ~reset & rd_pend & ~rd_owner;
  assign m1_readdatavalid = ~reset & rd_pend & rd_owner;

  always_ff @(posedge clk) begin
    if (reset) begin
      prio           <= 1'b0;
      rd_pend        <= 1'b0;
      rd_owner       <= 1'b0;
      last_address   <= '0;
      last_writedata <= '0;
    end else begin
      rd_pend <= gnt_any & ~sel_write;
      if (gnt_any) begin
        rd_owner       <= gnt1;
        last_address   <= sel_address;
        last_writedata <= sel_writedata;
        // Hand the tie to the master that was not just served.
        if (RR) prio <= gnt0;
      end
    end
  end

endmodule

// File: tb/tb_qsys_data_mem_arbiter.sv
// tb/tb_qsys_data_mem_arbiter.sv - self-checking bench for qsys_data_mem_arbiter
module tb_qsys_data_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        freeze;
  logic [11:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [11:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata, mem_readdata;

  // Second instance with fixed priority; both of its masters read constantly.
  logic        b_m0_waitrequest, b_m1_waitrequest;
  logic [31:0] b_m0_readdata, b_m1_readdata;
  logic        b_m0_readdatavalid, b_m1_readdatavalid;
  logic [11:0] b_mem_address;
  logic [3:0]  b_mem_byteenable;
  logic        b_mem_chipselect, b_mem_write, b_mem_clken;
  logic [31:0] b_mem_writedata;

  qsys_data_mem_arbiter #(.AW(12), .DW(32), .ROUND_ROBIN(1)) dut (
    .clk(clk), .reset(reset), .freeze(freeze),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  qsys_data_mem_arbiter #(.AW(12), .DW(32), .ROUND_ROBIN(0)) dut_fixed (
    .clk(clk), .reset(reset), .freeze(freeze),
    .m0_address(12'h010), .m0_byteenable(4'hF), .m0_read(1'b1),
    .m0_write(1'b0), .m0_writedata(32'h0), .m0_waitrequest(b_m0_waitrequest),
    .m0_readdata(b_m0_readdata), .m0_readdatavalid(b_m0_readdatavalid),
    .m1_address(12'h020), .m1_byteenable(4'hF), .m1_read(1'b1),
    .m1_write(1'b0), .m1_writedata(32'h0), .m1_waitrequest(b_m1_waitrequest),
    .m1_readdata(b_m1_readdata), .m1_readdatavalid(b_m1_readdatavalid),
    .mem_address(b_mem_address), .mem_byteenable(b_mem_byteenable),
    .mem_chipselect(b_mem_chipselect), .mem_write(b_mem_write),
    .mem_writedata(b_mem_writedata), .mem_clken(b_mem_clken), .mem_readdata(32'h0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory emulator: registered address, unregistered q, byte-enabled writes.
  logic [31:0] emu_mem [4096];
  logic [11:0] emu_addr;
  logic        mem_init;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 4096; i++) emu_mem[i] <= '0;
      emu_addr <= '0;
    end else if (mem_clken) begin
      emu_addr <= mem_address;
      if (mem_chipselect && mem_write)
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) emu_mem[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
    end
  end
  assign mem_readdata = emu_mem[emu_addr];

  // Reference model state.
  logic [31:0] ref_mem [4096];
  logic        ref_prio, ref_last_valid;
  logic [11:0] ref_last_addr;
  logic        exp_rdv0, exp_rdv1, b_prev;
  logic [31:0] exp_data;
  logic        lg0, lg1, prev_g0;
  int          errors, checks;

  // Per-master pending request: k=0 idle, 1 read, 2 write. Held until granted.
  logic        rst, frz;
  logic [1:0]  k0, k1;
  logic [11:0] a0, a1;
  logic [31:0] d0, d1;
  logic [3:0]  e0, e1;

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    logic        g0, g1, wr;
    logic [11:0] ga;
    logic [31:0] gd;
    logic [3:0]  ge;
    @(negedge clk);
    reset = rst; freeze = frz;
    m0_read = (k0 == 2'd1); m0_write = (k0 == 2'd2);
    m0_address = a0; m0_writedata = d0; m0_byteenable = e0;
    m1_read = (k1 == 2'd1); m1_write = (k1 == 2'd2);
    m1_address = a1; m1_writedata = d1; m1_byteenable = e1;
    #1;
    g0 = 1'b0; g1 = 1'b0;
    if (!rst && !frz) begin
      if (k0 != 2'd0 && k1 != 2'd0) begin
        g0 = !ref_prio; g1 = ref_prio;
      end else begin
        g0 = (k0 != 2'd0); g1 = (k1 != 2'd0);
      end
    end
    wr = (g0 && k0 == 2'd2) || (g1 && k1 == 2'd2);
    ga = g0 ? a0 : a1;
    gd = g0 ? d0 : d1;
    ge = g0 ? e0 : e1;

    check(m0_waitrequest, !g0, "m0_waitrequest");
    check(m1_waitrequest, !g1, "m1_waitrequest");
    check(m0_readdatavalid, exp_rdv0 && !rst, "m0_readdatavalid");
    check(m1_readdatavalid, exp_rdv1 && !rst, "m1_readdatavalid");
    if ((exp_rdv0 || exp_rdv1) && !rst) begin
      check(m0_readdata, exp_data, "m0_readdata");
      check(m1_readdata, exp_data, "m1_readdata");
    end
    check(mem_chipselect, g0 || g1, "mem_chipselect");
    check(mem_write, wr, "mem_write");
    check(mem_clken, !frz, "mem_clken");
    if (g0 || g1) begin
      check(mem_address, ga, "mem_address");
      check(mem_byteenable, wr ? ge : 4'hF, "mem_byteenable");
      if (wr) check(mem_writedata, gd, "mem_writedata");
    end else if (ref_last_valid) begin
      check(mem_address, ref_last_addr, "mem_address_hold");
    end
    check(b_m0_waitrequest, rst || frz, "fixed_m0_waitrequest");
    check(b_m1_waitrequest, 1'b1, "fixed_m1_waitrequest");
    check(b_m0_readdatavalid, b_prev && !rst, "fixed_m0_readdatavalid");
    check(b_m1_readdatavalid, 1'b0, "fixed_m1_readdatavalid");

    // Effects of the coming clock edge.
    exp_rdv0 = g0 && !wr;
    exp_rdv1 = g1 && !wr;
    if (g0 || g1) begin
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (ge[b]) ref_mem[ga][8*b +: 8] = gd[8*b +: 8];
      end else begin
        exp_data = ref_mem[ga];
      end
      ref_last_addr  = ga;
      ref_last_valid = 1'b1;
      ref_prio       = g0;
      if (g0) k0 = 2'd0;
      else    k1 = 2'd0;
    end
    b_prev = !rst && !frz;
    if (rst) begin
      ref_prio = 1'b0;
      ref_last_valid = 1'b0;
    end
    lg0 = g0; lg1 = g1;
  endtask

  initial begin
    errors = 0; checks = 0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
    ref_prio = 1'b0; ref_last_valid = 1'b0; ref_last_addr = '0;
    exp_rdv0 = 1'b0; exp_rdv1 = 1'b0; exp_data = '0; b_prev = 1'b0;
    lg0 = 1'b0; lg1 = 1'b0; prev_g0 = 1'b0;
    rst = 1'b1; frz = 1'b0; mem_init = 1'b1;
    k0 = 2'd0; k1 = 2'd0; a0 = '0; a1 = '0; d0 = '0; d1 = '0; e0 = 4'hF; e1 = 4'hF;
    reset = 1'b1; freeze = 1'b0;
    m0_read = 1'b0; m0_write = 1'b0; m0_address = '0; m0_writedata = '0; m0_byteenable = 4'hF;
    m1_read = 1'b0; m1_write = 1'b0; m1_address = '0; m1_writedata = '0; m1_byteenable = 4'hF;

    // Reset with a request present: nothing may be accepted.
    k1 = 2'd1; a1 = 12'h003;
    repeat (3) cycle();
    mem_init = 1'b0;
    rst = 1'b0;
    k1 = 2'd0;

    // Full-word write then read back.
    k0 = 2'd2; a0 = 12'h0A5; d0 = 32'hDEADBEEF; e0 = 4'hF; cycle();
    k0 = 2'd1; cycle();
    cycle();
    check(m0_readdatavalid, 1'b1, "read_deadbeef_valid");
    check(m0_readdata, 32'hDEADBEEF, "read_deadbeef_data");

    // Single-lane write, immediately followed by a read of the same word.
    k0 = 2'd2; d0 = 32'h00001200; e0 = 4'b0010; cycle();
    k0 = 2'd1; cycle();
    cycle();
    check(m0_readdata, 32'hDEAD12EF, "byte_lane_merge");

    // Both masters reading continuously: grants must alternate.
    for (int i = 0; i < 8; i++) begin
      k0 = 2'd1; k1 = 2'd1;
      a0 = 12'($urandom_range(0, 7)); a1 = 12'($urandom_range(0, 7));
      cycle();
      check(lg0 ^ lg1, 1'b1, "rr_one_grant");
      if (i > 0) check(lg0, !prev_g0, "rr_alternate");
      prev_g0 = lg0;
    end
    k0 = 2'd0; k1 = 2'd0;
    cycle();

    // Read accepted, freeze next cycle: data still returned, nothing accepted.
    k0 = 2'd1; a0 = 12'h0A5; cycle();
    frz = 1'b1; k0 = 2'd1; k1 = 2'd1; cycle();
    check(m0_readdatavalid, 1'b1, "freeze_rdv");
    check(m0_readdata, 32'hDEAD12EF, "freeze_rdata");
    cycle();
    frz = 1'b0; cycle();
    check(lg1, 1'b1, "prio_held_through_freeze");
    k0 = 2'd0; k1 = 2'd0;
    cycle();

    // Read accepted, reset next cycle: response dropped, priority back to m0.
    k0 = 2'd1; a0 = 12'h0A5; cycle();
    rst = 1'b1; k0 = 2'd1; k1 = 2'd1; cycle();
    check(m0_readdatavalid, 1'b0, "reset_drops_rdv");
    check(mem_chipselect, 1'b0, "reset_chipselect");
    rst = 1'b0; cycle();
    check(m0_readdatavalid, 1'b0, "no_rdv_after_reset");
    check(lg0, 1'b1, "prio_after_reset");
    k0 = 2'd0; k1 = 2'd0;
    cycle();

    // Randomized traffic with occasional freeze.
    for (int n = 0; n < 300; n++) begin
      if (k0 == 2'd0 && $urandom_range(0, 3) != 0) begin
        k0 = 2'($urandom_range(1, 2)); a0 = 12'($urandom_range(0, 7));
        d0 = $urandom; e0 = 4'($urandom_range(1, 15));
      end
      if (k1 == 2'd0 && $urandom_range(0, 3) != 0) begin
        k1 = 2'($urandom_range(1, 2)); a1 = 12'($urandom_range(0, 7));
        d1 = $urandom; e1 = 4'($urandom_range(1, 15));
      end
      frz = ($urandom_range(0, 9) == 0);
      cycle();
    end
    frz = 1'b0; k0 = 2'd0; k1 = 2'd0;
    repeat (2) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
